// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locked sharing of one uart_tx byte channel
// Optional idle-grant watchdog enabled by defining TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_new_data,
  output logic [NUM_REQ-1:0]   req_busy,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic                 timeout
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOCKED, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               new_q, new_d;

  logic [NUM_REQ-1:0] req_eff;
  logic               accept;
  logic               revoke;
  logic               found;
  logic [IW-1:0]      pick;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_busy[i] = ~grant_q[i] | tx_busy | new_q | (state_q != LOCKED);
    end
  end

  assign accept = req_new_data[gidx_q] & ~req_busy[gidx_q];

  // First pending requester after the last one served, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_eff[(int'(last_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    new_d     = 1'b0;
    if (accept) begin
      tx_data_d = req_data[8*gidx_q +: 8];
      new_d     = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          gidx_d  = pick;
          grant_d = NUM_REQ'(1) << pick;
        end
      end
      LOCKED: begin
        // A byte accepted on the release cycle still goes out, so drain it too.
        if (!req[gidx_q] || revoke) begin
          grant_d = '0;
          last_d  = gidx_q;
          state_d = (new_q || tx_busy || accept) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!new_q && !tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      tx_data_q <= 8'h00;
      new_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      new_q     <= new_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic               timeout_q;

  assign req_eff = req & ~mask_q;
  assign revoke  = (state_q == LOCKED) && !accept && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // A revoked requester stays masked until its req has been seen low once.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q & req;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == LOCKED) begin
      cnt_d = accept ? '0 : cnt_q + 1'b1;
    end
    if (revoke) mask_d[gidx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= revoke;
    end
  end

  assign timeout = timeout_q;
`else
  assign req_eff = req;
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a 10-cycle uart_tx model
module tb_uart_tx_arbiter;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  grant;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_new_data = 2'b00;
  logic [1:0]  req_busy;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic        timeout;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int unsigned exp_cyc[$];
  int unsigned last_accept = 0;
  logic [3:0]  bcnt = 4'd0;

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .req_data(req_data),
    .req_new_data(req_new_data), .req_busy(req_busy), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: busy for 10 cycles after each strobe
  always @(posedge clk) begin
    if (new_tx_data) bcnt <= 4'd10;
    else if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
  end
  assign tx_busy = (bcnt != 4'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input logic [7:0] b, input bit push, input bit drop);
    int n;
    n = 0;
    while (req_busy[r] && n < 200) begin
      tick();
      n++;
    end
    chk("busy_wait", 32'(n < 200), 32'd1);
    req_data[8*r +: 8] = b;
    req_new_data[r] = 1'b1;
    if (drop) req[r] = 1'b0;
    if (push) begin
      exp_q.push_back(b);
      exp_cyc.push_back(cyc + 1);
    end
    last_accept = cyc + 1;
    tick();
    req_new_data[r] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && new_tx_data) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got %02h expected no output", tx_data);
      end else begin
        logic [7:0]  b;
        int unsigned c;
        b = exp_q.pop_front();
        c = exp_cyc.pop_front();
        chk("tx_byte", 32'(tx_data), 32'(b));
        chk("tx_latency", cyc, c);
      end
    end
  end

  initial begin
    int n;
    int unsigned g0;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_new", 32'(new_tx_data), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h0);
    chk("rst_busy", 32'(req_busy), 32'h3);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b1;
    tick();
    chk("idle_no_req", 32'(grant), 32'h0);
    req = 2'b11;
    tick();
    chk("first_grant", 32'(grant), 32'h1);

    for (int i = 0; i < 5; i++) begin
      send(0, hello[i], 1'b1, 1'b0);
      chk("busy_after_byte", 32'(req_busy[0]), 32'h1);
      if (i == 1) begin
        chk("intruder_busy", 32'(req_busy[1]), 32'h1);
        req_data[15:8] = 8'h31;
        req_new_data[1] = 1'b1;
        tick();
        req_new_data[1] = 1'b0;
        chk("grant_hold", 32'(grant), 32'h1);
      end
    end
    tick();
    tick();
    chk("tx_data_hold", 32'(tx_data), 32'h6F);

    send(0, 8'h0A, 1'b1, 1'b1);
    chk("release_grant", 32'(grant), 32'h0);
    n = 0;
    while (grant == 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_gap", cyc - last_accept, 32'd13);
    chk("second_grant", 32'(grant), 32'h2);

    send(1, 8'h41, 1'b0, 1'b0);
    chk("mid_new", 32'(new_tx_data), 32'h1);
    chk("mid_data", 32'(tx_data), 32'h41);
    #1 rst = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_new", 32'(new_tx_data), 32'h0);
    chk("async_data", 32'(tx_data), 32'h0);
    req = 2'b11;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_grant", 32'(grant), 32'h1);

    req = 2'b10;
    tick();
    req = 2'b11;
    n = 0;
    while (grant == 2'b00 || grant == 2'b01) begin
      if (n >= 40) break;
      tick();
      n++;
    end
    chk("rr_yield", 32'(grant), 32'h2);

`ifdef TX_ARB_TIMEOUT_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    while (tx_busy && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("to_grant", 32'(grant), 32'h1);
    g0 = cyc;
    n = 0;
    while (!timeout && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycle", cyc - g0, 32'd16);
    chk("to_revoke", 32'(grant), 32'h0);
    tick();
    chk("to_timeout_pulse", 32'(timeout), 32'h0);
    chk("to_next", 32'(grant), 32'h2);
    req = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    chk("to_masked", 32'(grant), 32'h0);
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    tick();
    chk("to_unmasked", 32'(grant), 32'h1);
`else
    g0 = cyc;
    for (int i = 0; i < 40; i++) tick();
    chk("no_timeout", 32'(timeout), 32'h0);
    chk("hold_grant", 32'(grant), 32'h2);
`endif

    req = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
